// File: rtl/ct_piu_csr_pkg.sv
// Shared state encoding, request field layout and sizing helpers for the PIU CSR arbiter.
package ct_piu_csr_pkg;

  localparam int unsigned OP_LSB  = 64;
  localparam int unsigned OP_W    = 16;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned RDATA_W = 128;
  localparam int unsigned REQ_W   = OP_LSB + OP_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  // Per-core request word: op in [79:64], data in [63:0]
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } csr_req_t;

  function automatic int unsigned core_id_w(input int unsigned num_core);
    return (num_core > 1) ? $clog2(num_core) : 1;
  endfunction

endpackage

// File: rtl/ct_piu_csr_arb_if.sv
// Core-side and register-block-side CSR signals; slave is the arbiter's view.
interface ct_piu_csr_arb_if #(
  parameter int unsigned NUM_CORE = 4
);
  import ct_piu_csr_pkg::*;

  logic [NUM_CORE-1:0]       ibiu_ciu_csr_sel;
  logic [NUM_CORE*REQ_W-1:0] ibiu_ciu_csr_wdata;
  logic [NUM_CORE-1:0]       ciu_ibiu_csr_cmplt;
  logic [RDATA_W-1:0]        ciu_ibiu_csr_rdata;
  logic                      piu_regs_sel;
  logic [OP_W-1:0]           piu_regs_op;
  logic [DATA_W-1:0]         piu_regs_wdata;
  logic                      regs_piu_cmplt;
  logic [DATA_W-1:0]         regs_piux_rdata;
  logic                      piu_xx_regs_no_op;
  logic                      ciu_csr_timeout;

  modport slave (
    input  ibiu_ciu_csr_sel, ibiu_ciu_csr_wdata, regs_piu_cmplt, regs_piux_rdata,
    output ciu_ibiu_csr_cmplt, ciu_ibiu_csr_rdata, piu_regs_sel, piu_regs_op,
           piu_regs_wdata, piu_xx_regs_no_op, ciu_csr_timeout
  );

  modport master (
    output ibiu_ciu_csr_sel, ibiu_ciu_csr_wdata, regs_piu_cmplt, regs_piux_rdata,
    input  ciu_ibiu_csr_cmplt, ciu_ibiu_csr_rdata, piu_regs_sel, piu_regs_op,
           piu_regs_wdata, piu_xx_regs_no_op, ciu_csr_timeout
  );

endinterface

// File: rtl/ct_piu_csr_rr_arb.sv
// Round-robin grant: lowest requesting index at or above ptr, wrapping to 0.
module ct_piu_csr_rr_arb import ct_piu_csr_pkg::*; #(
  parameter  int unsigned NUM_CORE = 4,
  localparam int unsigned ID_W     = core_id_w(NUM_CORE)
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic [NUM_CORE-1:0] req,
  input  logic                take,
  output logic                grant_vld_c,
  output logic [ID_W-1:0]     grant_id_c
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            hi_vld, lo_vld;
  logic [ID_W-1:0] hi_id, lo_id;

  // Descending scan so the last hit in each half is the lowest index
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = int'(NUM_CORE) - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (ID_W'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(i);
        end else begin
          lo_vld = 1'b1;
          lo_id  = ID_W'(i);
        end
      end
    end
    grant_vld_c = hi_vld | lo_vld;
    grant_id_c  = hi_vld ? hi_id : lo_id;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take && grant_vld_c) begin
      ptr_d = (grant_id_c == ID_W'(NUM_CORE - 1)) ? '0 : grant_id_c + ID_W'(1);
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ct_piu_csr_arb.sv
// Arbitrates per-core CSR requests onto the single register-block port, one
// transaction in flight, with a WAIT timeout that returns zero data.
module ct_piu_csr_arb import ct_piu_csr_pkg::*; #(
  parameter int unsigned NUM_CORE    = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input logic             forever_cpuclk,
  input logic             cpurst,
  ct_piu_csr_arb_if.slave bus
);

  localparam int unsigned          ID_W    = core_id_w(NUM_CORE);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  csr_state_e           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]      id_q, id_d;
  csr_req_t             req_q, req_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 tout_q, tout_d;
  logic [NUM_CORE-1:0]  cmplt_q, cmplt_d;
  logic                 regs_sel_q, regs_sel_d;
  logic                 no_op_q, no_op_d;

  logic                 grant_vld_c;
  logic [ID_W-1:0]      grant_id_c;
  logic                 take_c;
  csr_req_t             grant_req_c;

  ct_piu_csr_rr_arb #(.NUM_CORE(NUM_CORE)) u_rr_arb (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .req            (bus.ibiu_ciu_csr_sel),
    .take           (take_c),
    .grant_vld_c    (grant_vld_c),
    .grant_id_c     (grant_id_c)
  );

  assign grant_req_c = csr_req_t'(bus.ibiu_ciu_csr_wdata[grant_id_c*REQ_W +: REQ_W]);

  // Next state; output registers are loaded from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    req_d   = req_q;
    rdata_d = '0;
    tout_d  = 1'b0;
    take_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_c) begin
          take_c  = 1'b1;
          id_d    = grant_id_c;
          req_d   = grant_req_c;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the last WAIT cycle beats the timeout
        if (bus.regs_piu_cmplt) begin
          rdata_d = bus.regs_piux_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          tout_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    regs_sel_d = (state_d == ST_ISSUE);
    no_op_d    = (state_d == ST_IDLE);
    cmplt_d    = (state_d == ST_RESP) ? (NUM_CORE'(1) << id_q) : '0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
      tout_q     <= 1'b0;
      cmplt_q    <= '0;
      regs_sel_q <= 1'b0;
      no_op_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      tout_q     <= tout_d;
      cmplt_q    <= cmplt_d;
      regs_sel_q <= regs_sel_d;
      no_op_q    <= no_op_d;
    end
  end

  assign bus.ciu_ibiu_csr_cmplt = cmplt_q;
  assign bus.ciu_ibiu_csr_rdata = {{(RDATA_W - DATA_W){1'b0}}, rdata_q};
  assign bus.piu_regs_sel       = regs_sel_q;
  assign bus.piu_regs_op        = req_q.op;
  assign bus.piu_regs_wdata     = req_q.data;
  assign bus.piu_xx_regs_no_op  = no_op_q;
  assign bus.ciu_csr_timeout    = tout_q;

endmodule

// File: tb/tb_ct_piu_csr_arb.sv
// Directed bench for ct_piu_csr_arb: reset, round-robin order and wrap,
// latency, timeout, completion/timeout coincidence and reset mid-transaction.
module tb_ct_piu_csr_arb;
  import ct_piu_csr_pkg::*;

  localparam int unsigned NC     = 4;
  localparam int unsigned TO_CYC = 16;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [NC-1:0] cmplt_seen;

  ct_piu_csr_arb_if #(.NUM_CORE(NC)) bus ();

  ct_piu_csr_arb #(.NUM_CORE(NC), .TIMEOUT_CYC(TO_CYC), .TIMEOUT_W(8)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .bus            (bus)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; each core drops sel the cycle after it saw its cmplt
  task automatic step();
    @(posedge forever_cpuclk);
    #1;
    cyc++;
    bus.ibiu_ciu_csr_sel = bus.ibiu_ciu_csr_sel & ~cmplt_seen;
    cmplt_seen = bus.ciu_ibiu_csr_cmplt;
  endtask

  // One transaction: regs cmplt 'lat' cycles after the issue pulse (0 = never)
  task automatic do_txn(input string tag, input int lat, input logic [63:0] rd,
                        input logic [NC-1:0] exp_oh, input int exp_dist,
                        input logic [63:0] exp_rd, input logic exp_to, output int t_issue);
    int n;
    int k;
    k = 0;
    for (int i = 0; i < int'(NC); i++) if (exp_oh[i]) k = i;
    bus.regs_piux_rdata = rd;
    n = 0;
    while (!bus.piu_regs_sel && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_issue"}, 128'(bus.piu_regs_sel), 128'(1));
    t_issue = cyc;
    chk({tag, "_op"}, 128'(bus.piu_regs_op), 128'(16'h0010 + k));
    chk({tag, "_wd"}, 128'(bus.piu_regs_wdata), 128'(64'hA3 + k));
    n = 0;
    forever begin
      step();
      n++;
      if (n == 1) chk({tag, "_selpulse"}, 128'(bus.piu_regs_sel), 128'(0));
      if ((|bus.ciu_ibiu_csr_cmplt) || n >= 40) break;
      bus.regs_piu_cmplt = (n == lat);
    end
    bus.regs_piu_cmplt = 1'b0;
    chk({tag, "_dist"}, 128'(n), 128'(exp_dist));
    chk({tag, "_oh"}, 128'(bus.ciu_ibiu_csr_cmplt), 128'(exp_oh));
    chk({tag, "_rdata"}, bus.ciu_ibiu_csr_rdata, {64'h0, exp_rd});
    chk({tag, "_tmo"}, 128'(bus.ciu_csr_timeout), 128'(exp_to));
    chk({tag, "_ophold"}, 128'(bus.piu_regs_op), 128'(16'h0010 + k));
    step();
    chk({tag, "_pulse"}, 128'({bus.ciu_ibiu_csr_cmplt, bus.ciu_csr_timeout}), 128'(0));
  endtask

  initial begin
    int            t0;
    int            t1;
    int            n;
    logic [NC-1:0] acc;
    logic          ctl;

    cpurst = 1'b1;
    cmplt_seen = '0;
    t0 = 0;
    bus.ibiu_ciu_csr_sel = '0;
    bus.regs_piu_cmplt   = 1'b0;
    bus.regs_piux_rdata  = '0;
    for (int i = 0; i < int'(NC); i++)
      bus.ibiu_ciu_csr_wdata[i*REQ_W +: REQ_W] = {16'(16'h0010 + i), 64'(64'hA3 + i)};

    step();
    step();
    chk("rst_no_op", 128'(bus.piu_xx_regs_no_op), 128'(1));
    chk("rst_cmplt", 128'(bus.ciu_ibiu_csr_cmplt), 128'(0));
    chk("rst_ctl", 128'({bus.piu_regs_sel, bus.ciu_csr_timeout}), 128'(0));
    chk("rst_rdata", bus.ciu_ibiu_csr_rdata, 128'(0));
    chk("rst_opwd", 128'({bus.piu_regs_op, bus.piu_regs_wdata}), 128'(0));
    cpurst = 1'b0;

    // All cores contend from ptr 0: order 0,1,2,3 at minimum latency, 4-cycle period
    bus.ibiu_ciu_csr_sel = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      do_txn($sformatf("rr%0d", k), 1, 64'h100 + 64'(k), NC'(1) << k, 2,
             64'h100 + 64'(k), 1'b0, t1);
      if (k > 0) chk($sformatf("rr%0d_period", k), 128'(t1 - t0), 128'(4));
      t0 = t1;
    end
    bus.ibiu_ciu_csr_sel = 4'b0001;
    do_txn("ptr0", 1, 64'h200, 4'b0001, 2, 64'h200, 1'b0, t1);

    // Single request, regs cmplt 3 cycles after issue; cmplt 5 cycles after sel
    bus.ibiu_ciu_csr_sel = 4'b0100;
    do_txn("single", 3, 64'h1234, 4'b0100, 4, 64'h1234, 1'b0, t1);

    // ptr is 3 now: core 3 first, then wrap to core 0
    bus.ibiu_ciu_csr_sel = 4'b1001;
    do_txn("wrap3", 1, 64'h33, 4'b1000, 2, 64'h33, 1'b0, t1);
    do_txn("wrap0", 1, 64'h44, 4'b0001, 2, 64'h44, 1'b0, t1);

    // Timeout after 16 WAIT cycles, zero data; a late regs cmplt is ignored
    bus.ibiu_ciu_csr_sel = 4'b0010;
    do_txn("tmo", 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 17, 64'h0, 1'b1, t1);
    bus.regs_piux_rdata = 64'hBAD;
    bus.regs_piu_cmplt  = 1'b1;
    acc = '0;
    ctl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.regs_piu_cmplt = 1'b0;
      acc |= bus.ciu_ibiu_csr_cmplt;
      ctl |= bus.piu_regs_sel;
    end
    chk("tmo_late_cmplt", 128'(acc), 128'(0));
    chk("tmo_late_idle", 128'({ctl, bus.piu_xx_regs_no_op}), 128'(2'b01));

    // Completion on the 16th WAIT cycle wins over the timeout
    bus.ibiu_ciu_csr_sel = 4'b0100;
    do_txn("coin", 16, 64'hC0FFEE, 4'b0100, 17, 64'hC0FFEE, 1'b0, t1);

    // Reset during WAIT (ptr moves to 2 on this grant, reset returns it to 0)
    bus.ibiu_ciu_csr_sel = 4'b0010;
    n = 0;
    while (!bus.piu_regs_sel && n < 8) begin
      step();
      n++;
    end
    chk("rstw_issue", 128'(bus.piu_regs_sel), 128'(1));
    step();
    cpurst = 1'b1;
    bus.ibiu_ciu_csr_sel = '0;
    step();
    cpurst = 1'b0;
    chk("rstw_no_op", 128'(bus.piu_xx_regs_no_op), 128'(1));
    chk("rstw_cmplt", 128'(bus.ciu_ibiu_csr_cmplt), 128'(0));
    chk("rstw_opwd", 128'({bus.piu_regs_op, bus.piu_regs_wdata}), 128'(0));
    bus.regs_piux_rdata = 64'h5555;
    bus.regs_piu_cmplt  = 1'b1;
    acc = '0;
    ctl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.regs_piu_cmplt = 1'b0;
      acc |= bus.ciu_ibiu_csr_cmplt;
      ctl |= bus.piu_regs_sel | bus.ciu_csr_timeout;
    end
    chk("rstw_late_cmplt", 128'(acc), 128'(0));
    chk("rstw_late_ctl", 128'(ctl), 128'(0));

    // ptr restarted at 0: core 0 before core 3
    bus.ibiu_ciu_csr_sel = 4'b1001;
    do_txn("prst0", 1, 64'h66, 4'b0001, 2, 64'h66, 1'b0, t1);
    do_txn("prst3", 1, 64'h77, 4'b1000, 2, 64'h77, 1'b0, t1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ct_piu_csr_arb.md
CT_PIU_CSR_ARB -- requirements
Module: ct_piu_csr_arb

Interface
REQ-001 The block SHALL take parameter NUM_CORE, default 4, as the number of requesting cores, legal range 1-8.
REQ-002 The block SHALL take parameter TIMEOUT_CYC, default 255, as the number of WAIT cycles before abort, legal range 1 to 2^TIMEOUT_W-1.
REQ-003 The block SHALL take parameter TIMEOUT_W, default 8, as the timeout counter width.
REQ-004 The port forever_cpuclk SHALL be input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The port cpurst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-006 The port ibiu_ciu_csr_sel SHALL be input, NUM_CORE bits: per-core request, held high until that core's cmplt is seen, dropped the following cycle.
REQ-007 The port ibiu_ciu_csr_wdata SHALL be input, NUM_CORE*80 bits: per core, [79:64] op and [63:0] data, stable while sel is high.
REQ-008 The port ciu_ibiu_csr_cmplt SHALL be output, NUM_CORE bits: one-cycle completion pulse to the granted core.
REQ-009 The port ciu_ibiu_csr_rdata SHALL be output, 128 bits: read data, valid only with cmplt.
REQ-010 The port piu_regs_sel SHALL be output, 1 bit: one-cycle issue pulse to the register block.
REQ-011 The port piu_regs_op SHALL be output, 16 bits: latched op.
REQ-012 The port piu_regs_wdata SHALL be output, 64 bits: latched data.
REQ-013 The port regs_piu_cmplt SHALL be input, 1 bit: register-block completion pulse.
REQ-014 The port regs_piux_rdata SHALL be input, 64 bits: register-block read data, valid with regs_piu_cmplt.
REQ-015 The port piu_xx_regs_no_op SHALL be output, 1 bit: high when the FSM is in IDLE.
REQ-016 The port ciu_csr_timeout SHALL be output, 1 bit: one-cycle pulse on a timed-out completion.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with one transaction outstanding at most.
REQ-018 In IDLE with any sel bit high, the block SHALL grant by round-robin, latch op, data and the granted core id, and go to ISSUE; with no sel bit high it SHALL stay in IDLE.
REQ-019 Round-robin SHALL grant the lowest index >= ptr with sel high, wrapping to index 0; after a grant to core k, ptr SHALL become (k+1) mod NUM_CORE; ptr SHALL be 0 after reset.
REQ-020 In ISSUE, piu_regs_sel SHALL be high for exactly one cycle; the next state SHALL be WAIT and the timeout counter SHALL clear.
REQ-021 In WAIT, on regs_piu_cmplt the block SHALL latch regs_piux_rdata and go to RESP.
REQ-022 In WAIT without regs_piu_cmplt, the counter SHALL increment; when it equals TIMEOUT_CYC-1 the block SHALL go to RESP with the latched rdata forced to 0 and a timeout flag set.
REQ-023 If regs_piu_cmplt and the timeout coincide, the completion SHALL win and no timeout SHALL be flagged.
REQ-024 In RESP, ciu_ibiu_csr_cmplt[id] SHALL be high for one cycle; ciu_ibiu_csr_rdata SHALL equal {64'b0, latched rdata}; ciu_csr_timeout SHALL equal the flag; the next state SHALL be IDLE.
REQ-025 regs_piu_cmplt SHALL be ignored outside WAIT.
REQ-026 sel changes on non-granted cores SHALL NOT disturb the transaction in flight.
REQ-027 piu_regs_op and piu_regs_wdata SHALL hold their latched values from ISSUE through RESP.
REQ-028 Minimum latency SHALL be: sel at cycle T, piu_regs_sel at T+1, regs_piu_cmplt at T+2, csr cmplt at T+3.
REQ-029 Back-to-back requests SHALL have a 4-cycle minimum period per transaction.
REQ-030 ciu_ibiu_csr_cmplt SHALL be one-hot or zero at all times.

Reset
REQ-031 While cpurst is high at a clock edge, the block SHALL go to IDLE, set ptr to 0, counter to 0, all outputs to 0 and piu_xx_regs_no_op to 1.
REQ-032 Reset mid-transaction SHALL abort it with no cmplt issued, and any later regs_piu_cmplt SHALL be ignored.

Structure
REQ-033 Package ct_piu_csr_pkg SHALL hold the FSM state encoding, the op and data field offsets (OP_LSB 64, OP_W 16, DATA_W 64), RDATA_W 128, and the core-id width function max(1, clog2(NUM_CORE)).
REQ-034 Sub-module ct_piu_csr_rr_arb SHALL contain the round-robin pointer and grant logic, parametrised by NUM_CORE.

Verification
REQ-035 Single request: NUM_CORE=4, sel=4'b0100, op=16'h0012, data=64'hA5, with regs cmplt 3 cycles after piu_regs_sel and rdata=64'h1234 -> cmplt=4'b0100 and rdata=128'h1234 at 5 cycles after sel rises.
REQ-036 Contention: sel=4'b1111 held, each core dropping after its cmplt -> grant order 0,1,2,3; next sel=4'b0001 with ptr=0 -> core 0 granted.
REQ-037 Wrap: ptr=3 and sel=4'b1001 -> core 3 granted first, then core 0.
REQ-038 Timeout: TIMEOUT_CYC=16 with no regs cmplt -> cmplt and ciu_csr_timeout pulse together, rdata=0, exactly 16 WAIT cycles; a regs cmplt arriving later is ignored.
REQ-039 Coincidence: regs cmplt on the 16th WAIT cycle -> real data returned and ciu_csr_timeout=0.
REQ-040 Reset in WAIT: cpurst pulsed for 1 cycle -> no cmplt, piu_xx_regs_no_op=1 the next cycle, and a later regs cmplt is ignored.
